// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg: shared constants and types for the execute stage.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ex_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    // Code 11 is not listed and falls back to the register file, like FWD_REG.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEM   = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam int REGWRITE_W = 2;
    localparam int MEMCTRL_W  = 2;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } ex_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_mul_iter.sv
// ---------------------------------------------------------------------------
// ex_mul_iter: radix-2 shift-add multiplier, one step per cycle, low product.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] product_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplr_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;

    // The product includes the step of the current cycle, so the final
    // value is ready in the same cycle the counter reaches its last value.
    assign product_o = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign done_o    = step_i && (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            mcand_q <= a_i;
            mplr_q  <= b_i;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (step_i) begin
            acc_q   <= product_o;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage: operand forwarding, ALU and EX/MEM register; EX_MUL_EN adds the
// iterative multiplier with its IDLE/MUL_BUSY stall FSM.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_AW-1:0]     rd_i,
    input  logic [3:0]            alu_ctrl_i,
    input  logic                  alu_src_i,
    input  logic [REGWRITE_W-1:0] reg_write_i,
    input  logic [MEMCTRL_W-1:0]  mem_ctrl_i,
    input  logic [1:0]            forwardA_i,
    input  logic [1:0]            forwardB_i,
    input  logic [DATA_W-1:0]     mem_wb_data_i,
    output logic                  stall_o,
    output logic                  ex_mem_valid_o,
    output logic [DATA_W-1:0]     ex_mem_alu_o,
    output logic [DATA_W-1:0]     ex_mem_wdata_o,
    output logic [REG_AW-1:0]     ex_mem_rd_o,
    output logic [REGWRITE_W-1:0] ex_mem_regwrite_o,
    output logic [MEMCTRL_W-1:0]  ex_mem_memctrl_o
);

    logic [DATA_W-1:0]     fwd_a;
    logic [DATA_W-1:0]     fwd_b;
    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     alu_res;

    logic                  ex_mem_valid_q,    ex_mem_valid_d;
    logic [DATA_W-1:0]     ex_mem_alu_q,      ex_mem_alu_d;
    logic [DATA_W-1:0]     ex_mem_wdata_q,    ex_mem_wdata_d;
    logic [REG_AW-1:0]     ex_mem_rd_q,       ex_mem_rd_d;
    logic [REGWRITE_W-1:0] ex_mem_regwrite_q, ex_mem_regwrite_d;
    logic [MEMCTRL_W-1:0]  ex_mem_memctrl_q,  ex_mem_memctrl_d;

    always_comb begin
        case (forwardA_i)
            FWD_EXMEM: fwd_a = ex_mem_alu_q;
            FWD_MEM:   fwd_a = mem_wb_data_i;
            default:   fwd_a = rs_data_i;
        endcase
        case (forwardB_i)
            FWD_EXMEM: fwd_b = ex_mem_alu_q;
            FWD_MEM:   fwd_b = mem_wb_data_i;
            default:   fwd_b = rt_data_i;
        endcase
        op_b = alu_src_i ? imm_i : fwd_b;
    end

    // MUL is absent here on purpose: single-cycle it reads as an unknown op.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl_i)
            ALU_AND: alu_res = fwd_a & op_b;
            ALU_OR:  alu_res = fwd_a | op_b;
            ALU_ADD: alu_res = fwd_a + op_b;
            ALU_SUB: alu_res = fwd_a - op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    ex_state_e             state_q;
    logic                  mul_busy;
    logic                  mul_start;
    logic                  mul_done;
    logic [DATA_W-1:0]     mul_prod;
    logic [REG_AW-1:0]     mul_rd_q;
    logic [REGWRITE_W-1:0] mul_rw_q;
    logic [MEMCTRL_W-1:0]  mul_mc_q;
    logic [DATA_W-1:0]     mul_wdata_q;

    assign mul_busy  = (state_q == ST_MUL_BUSY);
    assign mul_start = !mul_busy && valid_i && (alu_ctrl_i == ALU_MUL);
    // Gated by reset so a MUL sitting in ID/EX during reset cannot stall.
    assign stall_o   = rst_i && (mul_start || (mul_busy && !mul_done));

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .step_i    (mul_busy),
        .a_i       (fwd_a),
        .b_i       (op_b),
        .product_o (mul_prod),
        .done_o    (mul_done)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            mul_rd_q    <= '0;
            mul_rw_q    <= '0;
            mul_mc_q    <= '0;
            mul_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mul_start) begin
                        state_q     <= ST_MUL_BUSY;
                        mul_rd_q    <= rd_i;
                        mul_rw_q    <= reg_write_i;
                        mul_mc_q    <= mem_ctrl_i;
                        mul_wdata_q <= fwd_b;
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign stall_o = 1'b0;
`endif

    always_comb begin
        ex_mem_valid_d    = valid_i;
        ex_mem_alu_d      = alu_res;
        ex_mem_wdata_d    = fwd_b;
        ex_mem_rd_d       = rd_i;
        ex_mem_regwrite_d = valid_i ? reg_write_i : '0;
        ex_mem_memctrl_d  = valid_i ? mem_ctrl_i : '0;
`ifdef EX_MUL_EN
        if (mul_busy && mul_done) begin
            ex_mem_valid_d    = 1'b1;
            ex_mem_alu_d      = mul_prod;
            ex_mem_wdata_d    = mul_wdata_q;
            ex_mem_rd_d       = mul_rd_q;
            ex_mem_regwrite_d = mul_rw_q;
            ex_mem_memctrl_d  = mul_mc_q;
        end else if (mul_busy || mul_start) begin
            ex_mem_valid_d    = 1'b0;
            ex_mem_regwrite_d = '0;
            ex_mem_memctrl_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_mem_valid_q    <= 1'b0;
            ex_mem_alu_q      <= '0;
            ex_mem_wdata_q    <= '0;
            ex_mem_rd_q       <= '0;
            ex_mem_regwrite_q <= '0;
            ex_mem_memctrl_q  <= '0;
        end else begin
            ex_mem_valid_q    <= ex_mem_valid_d;
            ex_mem_alu_q      <= ex_mem_alu_d;
            ex_mem_wdata_q    <= ex_mem_wdata_d;
            ex_mem_rd_q       <= ex_mem_rd_d;
            ex_mem_regwrite_q <= ex_mem_regwrite_d;
            ex_mem_memctrl_q  <= ex_mem_memctrl_d;
        end
    end

    assign ex_mem_valid_o    = ex_mem_valid_q;
    assign ex_mem_alu_o      = ex_mem_alu_q;
    assign ex_mem_wdata_o    = ex_mem_wdata_q;
    assign ex_mem_rd_o       = ex_mem_rd_q;
    assign ex_mem_regwrite_o = ex_mem_regwrite_q;
    assign ex_mem_memctrl_o  = ex_mem_memctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage: directed vectors with a scoreboard queue checked by a monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk_i;
    logic              rst_i;
    logic              valid_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_AW-1:0] rd_i;
    logic [3:0]        alu_ctrl_i;
    logic              alu_src_i;
    logic [1:0]        reg_write_i;
    logic [1:0]        mem_ctrl_i;
    logic [1:0]        forwardA_i;
    logic [1:0]        forwardB_i;
    logic [DATA_W-1:0] mem_wb_data_i;
    logic              stall_o;
    logic              ex_mem_valid_o;
    logic [DATA_W-1:0] ex_mem_alu_o;
    logic [DATA_W-1:0] ex_mem_wdata_o;
    logic [REG_AW-1:0] ex_mem_rd_o;
    logic [1:0]        ex_mem_regwrite_o;
    logic [1:0]        ex_mem_memctrl_o;

    ex_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .valid_i           (valid_i),
        .rs_data_i         (rs_data_i),
        .rt_data_i         (rt_data_i),
        .imm_i             (imm_i),
        .rd_i              (rd_i),
        .alu_ctrl_i        (alu_ctrl_i),
        .alu_src_i         (alu_src_i),
        .reg_write_i       (reg_write_i),
        .mem_ctrl_i        (mem_ctrl_i),
        .forwardA_i        (forwardA_i),
        .forwardB_i        (forwardB_i),
        .mem_wb_data_i     (mem_wb_data_i),
        .stall_o           (stall_o),
        .ex_mem_valid_o    (ex_mem_valid_o),
        .ex_mem_alu_o      (ex_mem_alu_o),
        .ex_mem_wdata_o    (ex_mem_wdata_o),
        .ex_mem_rd_o       (ex_mem_rd_o),
        .ex_mem_regwrite_o (ex_mem_regwrite_o),
        .ex_mem_memctrl_o  (ex_mem_memctrl_o)
    );

    typedef struct {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wd;
        logic [REG_AW-1:0] rd;
        logic [1:0]        rw;
        logic [1:0]        mc;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   last_stall = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid EX/MEM entry must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i && ex_mem_valid_o) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=%h required=none", ex_mem_alu_o);
                end else begin
                    e = q.pop_front();
                    chk("sb_alu", ex_mem_alu_o, e.alu);
                    chk("sb_wdata", ex_mem_wdata_o, e.wd);
                    chk("sb_rd", DATA_W'(ex_mem_rd_o), DATA_W'(e.rd));
                    chk("sb_regwrite", DATA_W'(ex_mem_regwrite_o), DATA_W'(e.rw));
                    chk("sb_memctrl", DATA_W'(ex_mem_memctrl_o), DATA_W'(e.mc));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [DATA_W-1:0] rs,
                         input logic [DATA_W-1:0] rt, input logic [DATA_W-1:0] imm, input logic src,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [DATA_W-1:0] mwb,
                         input logic [REG_AW-1:0] rd, input logic [1:0] rw, input logic [1:0] mc);
        valid_i = v; alu_ctrl_i = op; rs_data_i = rs; rt_data_i = rt; imm_i = imm;
        alu_src_i = src; forwardA_i = fa; forwardB_i = fb; mem_wb_data_i = mwb;
        rd_i = rd; reg_write_i = rw; mem_ctrl_i = mc;
    endtask

    // Present one instruction, hold it through any stall, return 1 after the capture edge.
    task automatic issue(input logic v, input logic [3:0] op, input logic [DATA_W-1:0] rs,
                         input logic [DATA_W-1:0] rt, input logic [DATA_W-1:0] imm, input logic src,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [DATA_W-1:0] mwb,
                         input logic [REG_AW-1:0] rd, input logic [1:0] rw, input logic [1:0] mc,
                         input logic [DATA_W-1:0] e_alu, input logic [DATA_W-1:0] e_wd);
        exp_t e;
        int   st;
        drive(v, op, rs, rt, imm, src, fa, fb, mwb, rd, rw, mc);
        if (v) begin
            e.alu = e_alu; e.wd = e_wd; e.rd = rd; e.rw = rw; e.mc = mc;
            q.push_back(e);
        end
        st = 0;
        @(negedge clk_i);
        while (stall_o && st < 100) begin
            st++;
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        last_stall = st;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 4'h0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            drive(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom),
                  2'($urandom), 2'($urandom), $urandom, 5'($urandom), 2'($urandom), 2'($urandom));
        end
        drive(1'b1, 4'b1000, 7, 6, 0, 0, 2'b00, 2'b00, 0, 9, 2'b10, 2'b00);
        @(negedge clk_i);
        chk("rst_valid", DATA_W'(ex_mem_valid_o), 0);
        chk("rst_alu", ex_mem_alu_o, 0);
        chk("rst_wdata", ex_mem_wdata_o, 0);
        chk("rst_rd", DATA_W'(ex_mem_rd_o), 0);
        chk("rst_regwrite", DATA_W'(ex_mem_regwrite_o), 0);
        chk("rst_memctrl", DATA_W'(ex_mem_memctrl_o), 0);
        chk("rst_stall", DATA_W'(stall_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        //     v  op       rs            rt          imm src fa     fb     mwb  rd rw     mc     exp_alu       exp_wd
        issue(1, 4'b0010, 1,            2,          0,  0, 2'b00, 2'b00, 0,   1, 2'b10, 2'b00, 3,            2);
        issue(1, 4'b0010, 2,            3,          0,  0, 2'b00, 2'b00, 0,   5, 2'b10, 2'b00, 5,            3);
        issue(1, 4'b0010, 100,          3,          0,  0, 2'b10, 2'b00, 0,   6, 2'b10, 2'b00, 8,            3);
        issue(1, 4'b0110, 10,           77,         0,  0, 2'b00, 2'b01, 4,   7, 2'b10, 2'b00, 6,            4);
        issue(1, 4'b0010, 20,           7,          0,  0, 2'b11, 2'b00, 999, 8, 2'b10, 2'b00, 27,           7);
        issue(1, 4'b0000, 32'hF0F0,     32'hFF00,   0,  0, 2'b00, 2'b00, 0,   2, 2'b10, 2'b00, 32'hF000,     32'hFF00);
        issue(1, 4'b0001, 32'hF0F0,     32'h0F00,   0,  0, 2'b00, 2'b00, 0,   3, 2'b10, 2'b00, 32'hFFF0,     32'h0F00);
        issue(1, 4'b0010, 100,          55,         4,  1, 2'b00, 2'b10, 0,   0, 2'b00, 2'b01, 104,          32'hFFF0);
        issue(1, 4'b0111, 32'hFFFFFFFF, 9,          1,  1, 2'b00, 2'b00, 0,   4, 2'b10, 2'b00, 1,            9);
        issue(1, 4'b0111, 5,            3,          0,  0, 2'b00, 2'b00, 0,   4, 2'b10, 2'b00, 0,            3);
        issue(1, 4'b0111, 3,            5,          0,  0, 2'b00, 2'b00, 0,   4, 2'b10, 2'b00, 1,            5);
        issue(1, 4'b0011, 1,            1,          0,  0, 2'b00, 2'b00, 0,   4, 2'b10, 2'b00, 0,            1);
        issue(1, 4'b0010, 32'hFFFFFFFF, 2,          0,  0, 2'b00, 2'b00, 0,   4, 2'b10, 2'b00, 1,            2);
        issue(1, 4'b0110, 0,            1,          0,  0, 2'b00, 2'b00, 0,   4, 2'b11, 2'b10, 32'hFFFFFFFF, 1);
        issue(0, 4'b0010, 1,            1,          0,  0, 2'b00, 2'b00, 0,   4, 2'b10, 2'b11, 0,            0);
        chk("bubble_valid", DATA_W'(ex_mem_valid_o), 0);
        chk("bubble_regwrite", DATA_W'(ex_mem_regwrite_o), 0);
        chk("bubble_memctrl", DATA_W'(ex_mem_memctrl_o), 0);

`ifdef EX_MUL_EN
        issue(1, 4'b1000, 7,            6,          0,  0, 2'b00, 2'b00, 0,   9, 2'b10, 2'b00, 42,           6);
        chk("mul_stall_cycles", DATA_W'(last_stall), DATA_W);
        issue(1, 4'b1000, 32'hFFFFFFFF, 2,          0,  0, 2'b00, 2'b00, 0,   10, 2'b10, 2'b00, 32'hFFFFFFFE, 2);
        chk("mul2_stall_cycles", DATA_W'(last_stall), DATA_W);
        issue(1, 4'b1000, 1234,         3,          0,  0, 2'b10, 2'b00, 0,   11, 2'b10, 2'b00, 32'hFFFFFFFA, 3);
        // Abort: reset in the tenth stall cycle of a MUL.
        drive(1, 4'b1000, 5, 5, 0, 0, 2'b00, 2'b00, 0, 12, 2'b10, 2'b00);
        repeat (9) @(negedge clk_i);
        @(negedge clk_i);
        chk("mid_mul_stall_before", DATA_W'(stall_o), 1);
`else
        issue(1, 4'b1000, 7,            6,          0,  0, 2'b00, 2'b00, 0,   9, 2'b10, 2'b00, 0,            6);
        chk("mul_disabled_stall", DATA_W'(last_stall), 0);
        issue(1, 4'b0010, 4,            4,          0,  0, 2'b00, 2'b00, 0,   12, 2'b10, 2'b00, 8,           4);
        @(negedge clk_i);
        chk("pre_reset_stall", DATA_W'(stall_o), 0);
`endif
        #1;
        rst_i = 1'b0;
        #1;
        chk("abort_stall", DATA_W'(stall_o), 0);
        chk("abort_valid", DATA_W'(ex_mem_valid_o), 0);
        chk("abort_alu", ex_mem_alu_o, 0);
        chk("abort_regwrite", DATA_W'(ex_mem_regwrite_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        issue(1, 4'b0010, 4,            5,          0,  0, 2'b00, 2'b00, 0,   13, 2'b10, 2'b00, 9,           5);
        chk("post_reset_stall", DATA_W'(last_stall), 0);

        drive(0, 4'h0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00);
        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", DATA_W'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
